// File: rtl/serial_addsub_seq.sv
// Bit-serial add/subtract sequencer driving an external 1-bit full-adder cell, LSB first.
// Define OVF_DETECT_EN to add the registered signed-overflow output ovf.
module serial_addsub_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef OVF_DETECT_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds only the upper WIDTH-1 collected sum bits; the bit that would
  // fall off the bottom of a full-width shifter is never observed.
  logic [WIDTH-2:0] s_sh;
  logic [WIDTH-1:0] s_next;
  logic             carry;
  logic [CW-1:0]    cnt;

  always_comb begin
    s_next = {fa_sum, s_sh};
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    if (state == S_RUN) begin
      fa_a   = a_sh[0];
      fa_b   = b_sh[0];
      fa_cin = carry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      s_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
`ifdef OVF_DETECT_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= op_sub ? ~b : b;
            carry <= op_sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          s_sh  <= s_next[WIDTH-1:1];
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_cout;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            result <= s_next;
            cout   <= fa_cout;
`ifdef OVF_DETECT_EN
            ovf    <= carry ^ fa_cout;
`endif
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
